// File: rtl/lsu_pkg.sv
// Shared encodings for the memory-stage load/store unit: the store/load
// opcodes coming from EX/MEM and the bus FSM state type.
package lsu_pkg;

    localparam logic [1:0] DM_NONE = 2'd0;
    localparam logic [1:0] DM_SB   = 2'd1;
    localparam logic [1:0] DM_SH   = 2'd2;
    localparam logic [1:0] DM_SW   = 2'd3;

    localparam logic [2:0] DM_LB   = 3'd1;
    localparam logic [2:0] DM_LH   = 3'd2;
    localparam logic [2:0] DM_LW   = 3'd3;
    localparam logic [2:0] DM_LBU  = 3'd4;
    localparam logic [2:0] DM_LHU  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

    // Codes 6 and 7 on r_dm are reserved and behave like "no load".
    function automatic logic is_load_op(input logic [2:0] r);
        return (r >= DM_LB) && (r <= DM_LHU);
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Single-port data memory bus between the LSU (master) and memory/cache (slave).
interface mem_stage_lsu_if;

    // Handshake: the master raises mem_req with mem_we/mem_addr/mem_wdata/mem_be
    // and holds all of them stable until it samples mem_ack=1 on a clock edge;
    // mem_rdata is only meaningful in that ack cycle, and mem_ack with no
    // outstanding request is ignored.
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store replication/byte enables, misalign
// detection for the incoming op, and extraction/extension of load data.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  w_dm_i,
    input  logic [2:0]  r_dm_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] data2_i,
    input  logic [2:0]  ld_op_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] rdata_i,
    output logic        access_o,
    output logic        is_store_o,
    output logic        misalign_o,
    output logic [31:0] wdata_o,
    output logic [3:0]  be_o,
    output logic [31:0] load_ext_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // A store on the same instruction overrides any load code.
    always_comb begin
        is_store_o = (w_dm_i != DM_NONE);
        access_o   = is_store_o || is_load_op(r_dm_i);
        misalign_o = 1'b0;
        wdata_o    = 32'h0;
        be_o       = 4'b1111;
        if (is_store_o) begin
            case (w_dm_i)
                DM_SB: begin
                    wdata_o = {4{data2_i[7:0]}};
                    be_o    = 4'b0001 << addr_lo_i;
                end
                DM_SH: begin
                    wdata_o    = {2{data2_i[15:0]}};
                    be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                    misalign_o = addr_lo_i[0];
                end
                default: begin
                    wdata_o    = data2_i;
                    misalign_o = |addr_lo_i;
                end
            endcase
        end else begin
            case (r_dm_i)
                DM_LH, DM_LHU: misalign_o = addr_lo_i[0];
                DM_LW:         misalign_o = |addr_lo_i;
                default:       misalign_o = 1'b0;
            endcase
        end
    end

    always_comb begin
        ld_byte = rdata_i[{ld_off_i, 3'b000} +: 8];
        ld_half = ld_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (ld_op_i)
            DM_LB:   load_ext_o = {{24{ld_byte[7]}}, ld_byte};
            DM_LH:   load_ext_o = {{16{ld_half[15]}}, ld_half};
            DM_LBU:  load_ext_o = {24'h0, ld_byte};
            DM_LHU:  load_ext_o = {16'h0, ld_half};
            default: load_ext_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues one bus transfer per access, stalls the
// upstream pipeline while it is outstanding, and returns formatted load data.
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic [1:0]         w_dm,
    input  logic [2:0]         r_dm,
    input  logic [31:0]        addr,
    input  logic [31:0]        data2,
    mem_stage_lsu_if.master    bus,
    output logic               stall,
    output logic [31:0]        load_data,
    output logic               load_valid,
    output logic               misalign_err,
    output logic               bus_err,
    output lsu_state_e         dbg_state_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             squash_q, squash_d;
    logic             is_load_q, is_load_d;
    logic [2:0]       ld_op_q, ld_op_d;
    logic [1:0]       ld_off_q, ld_off_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      load_data_q, load_data_d;
    logic             load_valid_q, load_valid_d;
    logic             bus_err_q, bus_err_d;

    logic             access;
    logic             is_store;
    logic             misalign;
    logic [31:0]      fmt_wdata;
    logic [3:0]       fmt_be;
    logic [31:0]      load_ext;

    lsu_align u_align (
        .w_dm_i     (w_dm),
        .r_dm_i     (r_dm),
        .addr_lo_i  (addr[1:0]),
        .data2_i    (data2),
        .ld_op_i    (ld_op_q),
        .ld_off_i   (ld_off_q),
        .rdata_i    (bus.mem_rdata),
        .access_o   (access),
        .is_store_o (is_store),
        .misalign_o (misalign),
        .wdata_o    (fmt_wdata),
        .be_o       (fmt_be),
        .load_ext_o (load_ext)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        squash_d     = squash_q;
        is_load_d    = is_load_q;
        ld_op_d      = ld_op_q;
        ld_off_d     = ld_off_q;
        req_d        = req_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        bus_err_d    = 1'b0;
        stall        = 1'b0;
        misalign_err = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (access && misalign) begin
                    misalign_err = 1'b1;
                end else if (access && !flush) begin
                    stall     = 1'b1;
                    req_d     = 1'b1;
                    we_d      = is_store;
                    addr_d    = {addr[31:2], 2'b00};
                    wdata_d   = fmt_wdata;
                    be_d      = fmt_be;
                    is_load_d = !is_store;
                    ld_op_d   = r_dm;
                    ld_off_d  = addr[1:0];
                    cnt_d     = '0;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                stall = 1'b1;
                // A flush cannot abort an issued transfer; it only suppresses the result.
                if (flush) begin
                    squash_d = 1'b1;
                end
                if (bus.mem_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_DONE;
                    if (is_load_q) begin
                        load_data_d  = load_ext;
                        load_valid_d = !(squash_q || flush);
                    end
                end else if (cnt_q == CNT_LAST) begin
                    req_d       = 1'b0;
                    bus_err_d   = 1'b1;
                    load_data_d = 32'h0;
                    state_d     = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                squash_d = 1'b0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            squash_q     <= 1'b0;
            is_load_q    <= 1'b0;
            ld_op_q      <= 3'd0;
            ld_off_q     <= 2'd0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            be_q         <= 4'h0;
            load_data_q  <= 32'h0;
            load_valid_q <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            squash_q     <= squash_d;
            is_load_q    <= is_load_d;
            ld_op_q      <= ld_op_d;
            ld_off_q     <= ld_off_d;
            req_q        <= req_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_be    = be_q;
    assign load_data     = load_data_q;
    assign load_valid    = load_valid_q;
    assign bus_err       = bus_err_q;
    assign dbg_state_o   = state_q;

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit of the 5-stage RISC-V pipeline.
- Consumes the EX/MEM register outputs: write-memory code, read-memory code, ALU address and store data.
- Drives a single-port data memory/cache bus with a req/ack handshake and formats store byte lanes and load data.
- Asserts stall to freeze the upstream pipeline registers while a bus transfer is outstanding.

Parameters:
TIMEOUT, 16, max BUSY cycles waiting for mem_ack before bus error; counter width $clog2(TIMEOUT+1)

Ports:
clk  input  1  pipeline clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
flush  input  1  squash current MEM-stage instruction (branch taken)
w_dm  input  2  store op: 0 none, 1 SB, 2 SH, 3 SW
r_dm  input  3  load op: 0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6-7 treated as none
addr  input  32  effective byte address (ALU result)
data2  input  32  store source data (rs2)
mem_ack  input  1  memory completes transfer this cycle
mem_rdata  input  32  read word, valid when mem_ack=1
mem_req  output  1  registered bus request
mem_we  output  1  registered write enable
mem_addr  output  32  registered word address {addr[31:2],2'b00}
mem_wdata  output  32  registered lane-replicated store data
mem_be  output  4  registered byte enables
stall  output  1  combinational; freeze PC, IF/ID, ID/EX, EX/MEM
load_data  output  32  registered, extended load result
load_valid  output  1  registered one-cycle pulse, load completed
misalign_err  output  1  combinational; misaligned access in IDLE
bus_err  output  1  registered one-cycle pulse, ack timeout

Behaviour:
- Reset (synchronous): state=IDLE; mem_req, mem_we, mem_addr, mem_wdata, mem_be, load_data, load_valid, bus_err, timeout counter, squash flag = 0.
- Reset also wins mid-transfer: mem_req drops next edge, no load_valid.
- Access present: w_dm!=0 or r_dm in 1..5. If both are nonzero, the store wins and the load is ignored.
- Misaligned:
  - Halfword with addr[0]=1.
  - Word with addr[1:0]!=0.
- IDLE:
  - Access, aligned, no flush: stall=1. At the edge, latch mem_addr, mem_we, mem_be and mem_wdata; latch the op and addr[1:0]; set mem_req=1; clear the counter; go BUSY.
  - Misaligned: misalign_err=1, stall=0, no request, stay IDLE.
  - flush or no access: stall=0, stay IDLE. mem_ack is ignored in IDLE.
- Store formatting:
  - SB: wdata={4{data2[7:0]}}, be=4'b0001<<addr[1:0].
  - SH: wdata={2{data2[15:0]}}, be=addr[1]?1100:0011.
  - SW: wdata=data2, be=1111.
- Loads: be=1111, mem_we=0.
- BUSY:
  - stall=1. mem_req and all bus outputs are held stable until ack.
  - flush in BUSY sets the squash flag. The transfer is not aborted, because a store already issued completes.
  - mem_ack=1: next edge mem_req=0. For a load, load_data=extracted lane with sign/zero extension, and load_valid=1 unless squash. Go DONE.
  - No ack and counter==TIMEOUT-1: next edge mem_req=0, bus_err=1, load_data=0, go DONE.
  - Otherwise increment the counter.
- DONE:
  - stall=0 for exactly one cycle. The pipeline advances on this edge; load_data is consumed by the MEM/WB register.
  - Next edge: load_valid=0, bus_err=0, squash=0, go IDLE unconditionally. The same instruction never retriggers.
- Minimum latency per access: 3 cycles (IDLE, BUSY with immediate ack, DONE).
- Load extraction: byte select rdata[8*a+7:8*a]; half select a[1]?rdata[31:16]:rdata[15:0]. LB/LH sign-extend, LBU/LHU zero-extend.

Decomposition:
- Shared package lsu_pkg:
  - w_dm/r_dm encodings (DM_NONE, DM_SB, DM_SH, DM_SW, DM_LB, DM_LH, DM_LW, DM_LBU, DM_LHU).
  - FSM state encodings ST_IDLE, ST_BUSY, ST_DONE.
- One combinational sub-module lsu_align:
  - Store lane replication and byte enables.
  - Load extraction and extension.
  - Misalign detection.

Test Plan:
- SW addr=0x100, data2=0xDEADBEEF, ack on first BUSY cycle -> mem_addr=0x100, be=1111, wdata=0xDEADBEEF, we=1; stall high 2 cycles then low 1 cycle.
- SB addr=0x203, data2=0x000000A5 -> mem_addr=0x200, be=1000, wdata=0xA5A5A5A5.
- LB addr=0x301, rdata=0x0000_8000 (byte1=0x80), ack after 3 cycles -> load_data=0xFFFFFF80, load_valid one pulse. Same data with LBU -> 0x00000080.
- LH addr=0x402, rdata=0x8001_1234 -> load_data=0xFFFF8001. LW addr=0x402 -> misalign_err=1, mem_req stays 0, stall=0.
- Load with mem_ack never asserted, TIMEOUT=16 -> mem_req high exactly 16 cycles, then bus_err pulse, load_data=0, stall released in DONE.
- Load in BUSY with flush pulse, then ack -> load_valid stays 0. reset asserted mid-BUSY -> all outputs 0 next edge, state IDLE.
